// File: rtl/vector_point_reader.sv
// vector_point_reader: walks a point frame buffer and drives X/Y DACs plus beam blanking.
// Optional macro VECTOR_SLEW_EN adds a SLEW state that ramps x_ch/y_ch by one LSB per clock.
module vector_point_reader #(
   parameter int ADDRESSWIDTH = 16,
   parameter int DATAWIDTH    = 18,
   parameter int OUT_WIDTH    = 8,
   parameter int CEASE_CYCLES = 64,
   parameter int MAX_POINTS   = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    go,
   output logic                    halt,
   output logic [ADDRESSWIDTH-1:0] addr,
   input  logic [DATAWIDTH-1:0]    data_in,
   output logic [OUT_WIDTH-1:0]    x_ch,
   output logic [OUT_WIDTH-1:0]    y_ch,
   output logic                    blank,
   output logic                    busy
);
   localparam int HOLD_N = (CEASE_CYCLES == 0) ? 1 : CEASE_CYCLES;
   localparam int CW = $clog2(HOLD_N) + 1;
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_N - 1);
   localparam logic [ADDRESSWIDTH-1:0] LAST_ADDR = ADDRESSWIDTH'(MAX_POINTS - 1);

`ifdef VECTOR_SLEW_EN
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DONE, SLEW} state_t;
`else
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, HOLD, DONE} state_t;
`endif

   state_t state, state_n;
   logic [CW-1:0] cnt;
   logic eof, hold_end;
   logic [OUT_WIDTH-1:0] dx, dy;

   assign eof      = data_in[17];
   assign dx       = OUT_WIDTH'(data_in[15:8]);
   assign dy       = OUT_WIDTH'(data_in[7:0]);
   assign hold_end = (cnt == HOLD_LAST);
   assign halt     = (state == DONE);
   assign busy     = (state != IDLE);

`ifdef VECTOR_SLEW_EN
   logic [OUT_WIDTH-1:0] tx, ty, sx, sy;
   assign sx = (x_ch < tx) ? x_ch + 1'b1 : (x_ch > tx) ? x_ch - 1'b1 : x_ch;
   assign sy = (y_ch < ty) ? y_ch + 1'b1 : (y_ch > ty) ? y_ch - 1'b1 : y_ch;
`endif

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // next-state decode; the frame runs to completion regardless of go once started
   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (go) state_n = FETCH;
         FETCH: state_n = WAIT;
`ifdef VECTOR_SLEW_EN
         WAIT:  state_n = eof ? DONE : (x_ch == dx && y_ch == dy) ? HOLD : SLEW;
         SLEW:  if (sx == tx && sy == ty) state_n = HOLD;
`else
         WAIT:  state_n = eof ? DONE : HOLD;
`endif
         HOLD:  if (hold_end) state_n = (addr == LAST_ADDR) ? DONE : FETCH;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // datapath: point load, hold counting, address advance; entering DONE rewinds and blanks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr  <= '0;
         x_ch  <= '0;
         y_ch  <= '0;
         blank <= 1'b1;
         cnt   <= '0;
`ifdef VECTOR_SLEW_EN
         tx    <= '0;
         ty    <= '0;
`endif
      end else begin
         case (state)
            WAIT: if (!eof) begin
               blank <= data_in[16];
`ifdef VECTOR_SLEW_EN
               tx    <= dx;
               ty    <= dy;
`else
               x_ch  <= dx;
               y_ch  <= dy;
`endif
            end
`ifdef VECTOR_SLEW_EN
            SLEW: begin
               x_ch <= sx;
               y_ch <= sy;
            end
`endif
            HOLD: begin
               cnt <= hold_end ? '0 : cnt + 1'b1;
               if (hold_end && addr != LAST_ADDR) addr <= addr + 1'b1;
            end
            default: ;
         endcase
         if (state_n == DONE) begin
            addr  <= '0;
            blank <= 1'b1;
         end
      end
   end
endmodule
